// File: rtl/mem_arbiter_ram_if.sv
// Requester-side bundle for mem_arbiter_ram: per-port request/op lanes in,
// one-hot grant/read-valid pulses and the shared read bus out.
interface mem_arbiter_ram_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8,
   parameter int NPORTS = 2
);
   logic [NPORTS-1:0]        req;
   logic [NPORTS-1:0]        rw;
   logic [NPORTS*ADDR_W-1:0] addr;
   logic [NPORTS*DATA_W-1:0] wdata;
   logic [NPORTS-1:0]        gnt;
   logic [NPORTS-1:0]        rvalid;
   logic [DATA_W-1:0]        rdata;
   logic                     busy;
   logic [15:0]              contention;

   modport master (
      output req, rw, addr, wdata,
      input  gnt, rvalid, rdata, busy, contention
   );

   modport slave (
      input  req, rw, addr, wdata,
      output gnt, rvalid, rdata, busy, contention
   );
endinterface

// File: rtl/mem_arbiter_ram.sv
// Round-robin arbitrated single-port RAM shared by NPORTS requesters.
// One access per two cycles; inputs of the winner are latched at grant.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for any req; arbitrates and latches winner's op
// S_ACCESS | performs latched write or read; read data + rvalid next cycle
module mem_arbiter_ram #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8,
   parameter int NPORTS = 2
) (
   input  logic             clk,
   input  logic             rst,
   mem_arbiter_ram_if.slave io_bus
);
   localparam int PTR_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;
   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_ACCESS = 1'b1
   } state_t;

   state_t              r_state;
   logic [PTR_W-1:0]    r_ptr;
   logic                r_rw;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [DATA_W-1:0]   r_rdata;
   logic [NPORTS-1:0]   r_gnt;
   logic [NPORTS-1:0]   r_rvalid;
   logic                r_busy;
   logic [15:0]         r_contention;
   logic [DATA_W-1:0]   r_mem [DEPTH];

   logic                w_found;
   logic [PTR_W-1:0]    w_winner;
   logic [NPORTS-1:0]   w_onehot;
   logic                w_sel_rw;
   logic [ADDR_W-1:0]   w_sel_addr;
   logic [DATA_W-1:0]   w_sel_wdata;
   logic                w_multi;
   logic [15:0]         w_cont_next;

   // Round-robin search starting one past the last granted port.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      for (int i = 1; i <= NPORTS; i++) begin
         if (!w_found && io_bus.req[PTR_W'((int'(r_ptr) + i) % NPORTS)]) begin
            w_found  = 1'b1;
            w_winner = PTR_W'((int'(r_ptr) + i) % NPORTS);
         end
      end
   end

   // Mux the winning port's operation onto the latch inputs.
   always_comb begin
      w_onehot           = '0;
      w_onehot[w_winner] = w_found;
      w_sel_rw           = io_bus.rw[w_winner];
      w_sel_addr         = io_bus.addr[int'(w_winner) * ADDR_W +: ADDR_W];
      w_sel_wdata        = io_bus.wdata[int'(w_winner) * DATA_W +: DATA_W];
   end

   // Saturating count of grants made while more than one port was asking.
   always_comb begin
      w_multi     = ($countones(io_bus.req) > 1);
      w_cont_next = r_contention;
      if (r_state == S_IDLE && w_found && w_multi && r_contention != 16'hFFFF) begin
         w_cont_next = r_contention + 16'd1;
      end
   end

   // Arbiter FSM with registered grant/valid/busy outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_ptr        <= PTR_W'(NPORTS - 1);
         r_rw         <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_rdata      <= '0;
         r_gnt        <= '0;
         r_rvalid     <= '0;
         r_busy       <= 1'b0;
         r_contention <= '0;
      end else begin
         r_contention <= w_cont_next;
         case (r_state)
            S_IDLE: begin
               r_rvalid <= '0;
               if (w_found) begin
                  r_state <= S_ACCESS;
                  r_busy  <= 1'b1;
                  r_gnt   <= w_onehot;
                  r_ptr   <= w_winner;
                  r_rw    <= w_sel_rw;
                  r_addr  <= w_sel_addr;
                  r_wdata <= w_sel_wdata;
               end
            end
            S_ACCESS: begin
               r_state  <= S_IDLE;
               r_busy   <= 1'b0;
               r_gnt    <= '0;
               r_rvalid <= r_rw ? '0 : r_gnt;
               if (!r_rw) begin
                  r_rdata <= r_mem[r_addr];
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Storage is not reset; a reset during ACCESS drops the state to IDLE
   // before the next edge, which cancels the pending write.
   always_ff @(posedge clk) begin
      if (r_state == S_ACCESS && r_rw) begin
         r_mem[r_addr] <= r_wdata;
      end
   end

   assign io_bus.gnt        = r_gnt;
   assign io_bus.rvalid     = r_rvalid;
   assign io_bus.rdata      = r_rdata;
   assign io_bus.busy       = r_busy;
   assign io_bus.contention = r_contention;

endmodule

// File: tb/tb_mem_arbiter_ram.sv
// Scoreboard bench for mem_arbiter_ram: the driver predicts each grant and
// read result from a plain array/round-robin model and queues them; an
// independent monitor pops and compares whenever gnt or rvalid fires.
module tb_mem_arbiter_ram;
   localparam int DW = 8;
   localparam int AW = 8;
   localparam int NP = 2;

   logic clk;
   logic rst;

   mem_arbiter_ram_if #(.DATA_W(DW), .ADDR_W(AW), .NPORTS(NP)) bus_if ();

   mem_arbiter_ram #(.DATA_W(DW), .ADDR_W(AW), .NPORTS(NP)) dut (
      .clk    (clk),
      .rst    (rst),
      .io_bus (bus_if)
   );

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [DW-1:0] m_mem [2**AW];
   int            m_last;
   logic [15:0]   m_cont;
   logic [DW-1:0] m_rdata;

   // requester state
   logic [NP-1:0] pending;
   logic          op_rw   [NP];
   logic [AW-1:0] op_addr [NP];
   logic [DW-1:0] op_data [NP];

   // scoreboard
   int            q_gnt [$];
   int            q_rp  [$];
   logic [DW-1:0] q_rd  [$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int pick(input logic [NP-1:0] m, input int last);
      for (int k = 1; k <= NP; k++) begin
         int p;
         p = (last + k) % NP;
         if (m[p]) return p;
      end
      return -1;
   endfunction

   task automatic drive();
      for (int p = 0; p < NP; p++) begin
         bus_if.req[p]              = pending[p];
         bus_if.rw[p]               = op_rw[p];
         bus_if.addr[p*AW +: AW]    = op_addr[p];
         bus_if.wdata[p*DW +: DW]   = op_data[p];
      end
   endtask

   task automatic set_op(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      op_rw[p]   = w;
      op_addr[p] = a;
      op_data[p] = d;
   endtask

   // Called at a negedge with the DUT idle and pending already driven.
   task automatic do_grant();
      int w;
      w = pick(pending, m_last);
      if (w < 0) return;
      if ($countones(pending) > 1 && m_cont != 16'hFFFF) m_cont = m_cont + 16'd1;
      m_last = w;
      q_gnt.push_back(w);
      if (op_rw[w]) m_mem[op_addr[w]] = op_data[w];
      else begin
         q_rp.push_back(w);
         q_rd.push_back(m_mem[op_addr[w]]);
      end
      @(posedge clk);
      @(negedge clk);
      chk("busy_access", 32'(bus_if.busy), 32'd1);
      // grant seen: drop req and scramble the lane to prove it was latched
      pending[w] = 1'b0;
      set_op(w, 1'($urandom), AW'($urandom), DW'($urandom));
      drive();
      @(posedge clk);
      @(negedge clk);
      chk("busy_idle", 32'(bus_if.busy), 32'd0);
      chk("contention", 32'(bus_if.contention), 32'(m_cont));
   endtask

   task automatic model_reset();
      m_last  = NP - 1;
      m_cont  = '0;
      m_rdata = '0;
      pending = '0;
      drive();
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_gnt"},        32'(bus_if.gnt),        32'd0);
      chk({tag, "_rvalid"},     32'(bus_if.rvalid),     32'd0);
      chk({tag, "_rdata"},      32'(bus_if.rdata),      32'd0);
      chk({tag, "_busy"},       32'(bus_if.busy),       32'd0);
      chk({tag, "_contention"}, 32'(bus_if.contention), 32'd0);
   endtask

   // Called at a negedge; leaves the bench at negedge+2 with rst low.
   task automatic reset_pulse();
      #2 rst = 1'b1;
      #1 check_outputs_zero("rst");
      model_reset();
      @(negedge clk);
      #2 rst = 1'b0;
   endtask

   // monitor: compares DUT pulses against the scoreboard queues
   initial begin
      int e;
      int p;
      logic [DW-1:0] d;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (bus_if.gnt != '0) begin
               if (q_gnt.size() == 0) chk("gnt_unexpected", 32'(bus_if.gnt), 32'd0);
               else begin
                  e = q_gnt.pop_front();
                  chk("gnt_port", 32'(bus_if.gnt), 32'(1 << e));
               end
            end
            if (bus_if.rvalid != '0) begin
               if (q_rp.size() == 0) chk("rvalid_unexpected", 32'(bus_if.rvalid), 32'd0);
               else begin
                  p = q_rp.pop_front();
                  d = q_rd.pop_front();
                  chk("rvalid_port", 32'(bus_if.rvalid), 32'(1 << p));
                  chk("rdata", 32'(bus_if.rdata), 32'(d));
                  m_rdata = d;
               end
            end else begin
               chk("rdata_hold", 32'(bus_if.rdata), 32'(m_rdata));
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      for (int p = 0; p < NP; p++) set_op(p, 1'b0, '0, '0);
      model_reset();
      @(negedge clk);
      #1 check_outputs_zero("por");
      #1 rst = 1'b0;

      // fill memory so every model entry is known; first grant right after reset
      for (int a = 0; a < 2**AW; a++) begin
         pending = '0;
         pending[a % NP] = 1'b1;
         set_op(a % NP, 1'b1, AW'(a), DW'($urandom));
         drive();
         do_grant();
      end

      // single port write then read back
      pending = 2'b01; set_op(0, 1'b1, 8'h10, 8'hA5); drive(); do_grant();
      pending = 2'b01; set_op(0, 1'b0, 8'h10, 8'h00); drive(); do_grant();
      chk("single_contention", 32'(bus_if.contention), 32'd0);

      // simultaneous reads just after reset: port0 first, then port1
      reset_pulse();
      pending = 2'b11;
      set_op(0, 1'b0, 8'h10, 8'h00);
      set_op(1, 1'b0, 8'h33, 8'h00);
      drive();
      do_grant();
      do_grant();
      chk("pair_contention", 32'(bus_if.contention), 32'd1);

      // continuous contention for 8 grants
      @(negedge clk);
      reset_pulse();
      for (int g = 0; g < 8; g++) begin
         pending = 2'b11;
         drive();
         do_grant();
      end
      chk("rr8_contention", 32'(bus_if.contention), 32'd8);

      // pointer=0, then port1 write 0xFF vs port0 read 0xFF
      pending = 2'b01; set_op(0, 1'b0, 8'h05, 8'h00); drive(); do_grant();
      pending = 2'b11;
      set_op(1, 1'b1, 8'hFF, 8'h3C);
      set_op(0, 1'b0, 8'hFF, 8'h00);
      drive();
      do_grant();
      do_grant();

      // write aborted by reset mid-access; read must return old contents
      begin
         int w;
         pending = 2'b01;
         set_op(0, 1'b1, 8'h20, 8'h77);
         drive();
         w = pick(pending, m_last);
         m_last = w;
         q_gnt.push_back(w);
         @(posedge clk);
         @(negedge clk);
         #2 rst = 1'b1;
         #1 check_outputs_zero("abort");
         model_reset();
         @(posedge clk);
         #1 check_outputs_zero("abort_edge");
         @(negedge clk);
         #2 rst = 1'b0;
      end
      pending = 2'b01; set_op(0, 1'b0, 8'h20, 8'h00); drive(); do_grant();

      // randomized traffic with idle gaps
      for (int r = 0; r < 300; r++) begin
         for (int p = 0; p < NP; p++) begin
            if (!pending[p] && $urandom_range(0, 1) == 1) begin
               pending[p] = 1'b1;
               set_op(p, 1'($urandom),
                      ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7)),
                      DW'($urandom));
            end
         end
         drive();
         if (pending != '0) do_grant();
         else begin
            @(posedge clk);
            @(negedge clk);
            chk("idle_busy", 32'(bus_if.busy), 32'd0);
         end
      end

      // saturation: preload near the top, then keep contending
      pending = '0;
      drive();
      force dut.r_contention = 16'hFFFD;
      @(posedge clk);
      @(negedge clk);
      release dut.r_contention;
      m_cont = 16'hFFFD;
      chk("sat_preload", 32'(bus_if.contention), 32'hFFFD);
      for (int g = 0; g < 4; g++) begin
         pending = 2'b11;
         drive();
         do_grant();
      end
      chk("sat_final", 32'(bus_if.contention), 32'hFFFF);

      pending = '0;
      drive();
      repeat (4) @(negedge clk);
      chk("gnt_queue_empty", 32'(q_gnt.size()), 32'd0);
      chk("rd_queue_empty",  32'(q_rp.size()),  32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
